hazard_forward_unit: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Shadows the destination-register state of the EX, MEM and WB stages in its own registers and drives the ALU forwarding selects (fw_alu1, fw_alu2).
- Generates load-use stalls and taken-branch flushes.
- Sits beside the datapath: decode-stage fields in; stall, flush and forwarding controls out.

---
 rtl/hazard_forward_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: shadows EX/MEM/WB destination
// state, selects ALU operand forwarding, and raises load-use stalls and branch flushes.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_d,
  input  logic [REG_ADDR_W-1:0] rs_addr_d,
  input  logic [REG_ADDR_W-1:0] rt_addr_d,
  input  logic                  use_rs_d,
  input  logic                  use_rt_d,
  input  logic [REG_ADDR_W-1:0] dst_addr_d,
  input  logic                  reg_write_d,
  input  logic                  mem_to_reg_d,
  input  logic                  branch_taken_e,
  output logic [1:0]            fw_alu1,
  output logic [1:0]            fw_alu2,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  use_rs;
    logic                  use_rt;
    logic [REG_ADDR_W-1:0] dst;
    logic                  reg_write;
    logic                  mem_to_reg;
  } ex_stage_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic                  reg_write;
  } wr_stage_t;

  ex_stage_t        ex_q, ex_d;
  wr_stage_t        mem_q, mem_d;
  wr_stage_t        wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic [1:0][1:0] fw_sel;
  logic [1:0]      lu_hit;
  logic            lu;

  // Per-operand forwarding and load-use match; index 0 is rs, index 1 is rt.
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    logic [REG_ADDR_W-1:0] ex_src;
    logic                  ex_used;
    logic [REG_ADDR_W-1:0] dec_src;
    logic                  dec_used;
    logic                  hit_mem;
    logic                  hit_wb;

    assign ex_src   = (gi == 0) ? ex_q.rs     : ex_q.rt;
    assign ex_used  = (gi == 0) ? ex_q.use_rs : ex_q.use_rt;
    assign dec_src  = (gi == 0) ? rs_addr_d   : rt_addr_d;
    assign dec_used = (gi == 0) ? use_rs_d    : use_rt_d;

    assign hit_mem = ex_used & mem_q.reg_write & (mem_q.dst != ZERO_REG) & (mem_q.dst == ex_src);
    assign hit_wb  = ex_used & wb_q.reg_write  & (wb_q.dst  != ZERO_REG) & (wb_q.dst  == ex_src);

    assign fw_sel[gi] = hit_mem ? SEL_MEM : (hit_wb ? SEL_WB : SEL_RF);
    assign lu_hit[gi] = dec_used & (dec_src == ex_q.dst);
  end

  assign lu = valid_d & ex_q.mem_to_reg & (ex_q.dst != ZERO_REG) & (|lu_hit);

  always_comb begin
    flush_d = branch_taken_e;
    flush_e = branch_taken_e | lu;
    // A taken branch discards the decode instruction, so its hazard is moot.
    stall_f = lu & ~branch_taken_e;
    stall_d = lu & ~branch_taken_e;
  end

  always_comb begin
    ex_d            = '0;
    ex_d.rs         = rs_addr_d;
    ex_d.rt         = rt_addr_d;
    ex_d.use_rs     = use_rs_d;
    ex_d.use_rt     = use_rt_d;
    ex_d.dst        = dst_addr_d;
    ex_d.reg_write  = reg_write_d & valid_d;
    ex_d.mem_to_reg = mem_to_reg_d & valid_d;
    if (flush_e) begin
      ex_d = '0;
    end

    mem_d.dst       = ex_q.dst;
    mem_d.reg_write = ex_q.reg_write;
    wb_d            = mem_q;

    stall_count_d = stall_count_q;
    if (lu && !branch_taken_e && stall_count_q != CNT_MAX) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end

    flush_count_d = flush_count_q;
    if (branch_taken_e && flush_count_q != CNT_MAX) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fw_alu1     = fw_sel[0];
  assign fw_alu2     = fw_sel[1];
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
